loop_counter_nd: RTL and testbench
==================================

// Module: loop_counter_nd
// PURPOSE
//   Parametrised multi-dimensional loop counter for BWN address sequencing.
//   NS cascaded stages of WL bits each; stage 0 is the innermost.
//   Each stage has a run-time programmable end-count. The block runs either
//   free-wrapping or as a one-shot sweep with a start/done handshake.
//   It drives the feature/weight address generators in the BWN datapath.
// PARAMETERS
//   NS      3   number of cascaded stages (>=1)
//   WL      8   width of each stage counter
//   ECV_DEF 13  end-count loaded into every stage at reset
// PORTS
//   iCLK    in   1      clock; all state changes on posedge
//   iRST    in   1      synchronous reset, active-low
//   iCLR    in   1      synchronous clear: counts to 0, FSM to IDLE
//   iLOAD   in   1      latch iECV into the end-count registers (IDLE only)
//   iECV    in   NS*WL  end-counts; stage k at [k*WL +: WL]
//   iMODE   in   1      0 = WRAP (free-run), 1 = ONESHOT; sampled on iSTART
//   iSTART  in   1      start a run (IDLE only)
//   iEN     in   1      advance enable, qualified by RUN
//   oCNT    out  NS*WL  registered stage counts; stage k at [k*WL +: WL]
//   oTC     out  NS     combinational carry-out: stage k and all lower stages at end-count
//   oBUSY   out  1      registered; 1 while FSM is in RUN
//   oDONE   out  1      registered; one-cycle pulse when the last combination completes
// BEHAVIOUR
//   Reset (iRST==0 at posedge):
//     oCNT=0, every ecv_reg=ECV_DEF, FSM=IDLE, mode_reg=0, oBUSY=0, oDONE=0.
//   Priority per edge: iRST > iCLR > iSTART/iLOAD > iEN.
//   FSM states: IDLE, RUN.
//     IDLE -> RUN when iSTART. On that edge: oCNT<=0, mode_reg<=iMODE, oBUSY<=1.
//     RUN -> IDLE on iCLR.
//     RUN -> IDLE on final wrap when mode_reg=ONESHOT.
//   iLOAD is accepted in IDLE only; it is ignored in RUN.
//     iLOAD and iSTART on the same edge: the run uses the new iECV.
//   iSTART in RUN is ignored.
//   Counting happens in RUN with iEN=1.
//     Stage k advances when all stages below k are at their end-count.
//     A stage at its end-count wraps to 0 when it advances; otherwise it adds 1.
//     Stage range is 0..ecv_reg[k] inclusive.
//     Period = prod(ecv_reg[k]+1) enables.
//   ecv_reg[k]==0: stage k stays at 0 and is permanently terminal; this is legal.
//   iEN=0, or FSM in IDLE: oCNT holds.
//   Latency: oCNT changes on the edge where iEN=1 is sampled (one-cycle registered).
//   Final wrap (oTC[NS-1]=1, iEN=1, RUN):
//     All stages go to 0 and oDONE=1 for one cycle.
//     WRAP mode: FSM stays in RUN.
//     ONESHOT mode: FSM goes to IDLE and oBUSY goes to 0 on the same edge.
//   oDONE is 0 on every other cycle, including after iCLR or reset.
//   iCLR or reset mid-run: no oDONE; oCNT=0 on the next cycle.
//     A reset or clear does not restore ecv_reg, except reset, which restores ECV_DEF.
// STRUCTURE
//   Package loop_cnt_pkg:
//     FSM state encoding ST_IDLE / ST_RUN.
//     Constants MODE_WRAP=1'b0, MODE_ONESHOT=1'b1.
//   Sub-module loop_cnt_stage: one WL-bit counter, end-count compare, carry in/out.
//     Instantiated NS times via generate, with the carry chained from stage k-1 to stage k.
//   Top level holds the FSM, mode_reg, ecv_reg array, oBUSY and oDONE.
// TESTING (NS=3, WL=8)
//   1 iRST=0 for 2 cycles, other inputs random -> oCNT=0, oBUSY=0, oDONE=0;
//     then iSTART with iEN=1 -> period is (14)^3 = 2744.
//   2 iLOAD iECV={2,3,4}, iSTART iMODE=1, iEN=1 held -> stage0 counts 0..4 and stage1 0..3;
//     oDONE pulses once after 60 enables; oBUSY falls on that edge; oCNT=0.
//   3 Same ECV, iMODE=0, 130 cycles of iEN=1 -> oDONE at enables 60 and 120; oBUSY stays 1.
//   4 ONESHOT with iEN toggling 1/0 -> oCNT holds on iEN=0 cycles; oDONE after the 60th enable.
//   5 In RUN at (1,2,3): iSTART and iLOAD={0,0,0} -> both ignored;
//     then iCLR -> oCNT=0, IDLE, no oDONE.
//   6 iRST=0 together with iCLR, iSTART, iEN=1 mid-run -> reset state wins;
//     then ECV={0,0,5} ONESHOT -> oDONE after 6 enables.

Source files
------------

// File: rtl/loop_cnt_pkg.sv
// Shared types and constants for the multi-dimensional loop counter.
package loop_cnt_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cntState_t;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/loop_cnt_stage.sv
// One counter stage: counts 0..endCnt inclusive and passes carry upward when terminal.
module loop_cnt_stage #(
    parameter int unsigned WL = 8
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          clear,
    input  logic          advance,
    input  logic          carryIn,
    input  logic [WL-1:0] endCnt,
    output logic [WL-1:0] count,
    output logic          carryOut
);

    logic atEnd;

    assign atEnd    = (count == endCnt);
    assign carryOut = carryIn && atEnd;

    // A zero end-count keeps the stage at 0 and permanently terminal.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance && carryIn) begin
            count <= atEnd ? '0 : count + WL'(1);
        end
    end

endmodule

// File: rtl/loop_counter_nd.sv
// NS-stage cascaded loop counter with programmable end-counts and wrap/one-shot runs.
module loop_counter_nd
    import loop_cnt_pkg::*;
#(
    parameter int unsigned NS      = 3,
    parameter int unsigned WL      = 8,
    parameter int unsigned ECV_DEF = 13
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iCLR,
    input  logic             iLOAD,
    input  logic [NS*WL-1:0] iECV,
    input  logic             iMODE,
    input  logic             iSTART,
    input  logic             iEN,
    output logic [NS*WL-1:0] oCNT,
    output logic [NS-1:0]    oTC,
    output logic             oBUSY,
    output logic             oDONE
);

    cntState_t     state, stateNext;
    logic          modeReg, modeNext;
    logic          busyNext, doneNext;
    logic          loadEcv, startRun, advance, clearCnt;
    logic [WL-1:0] ecvReg [NS];
    logic [NS:0]   carry;

    assign carry[0] = 1'b1;
    assign oTC      = carry[NS:1];
    assign advance  = (state == ST_RUN) && iEN && !iCLR;
    assign clearCnt = iCLR || startRun;

    // Stage k advances only when every lower stage is terminal.
    for (genvar k = 0; k < NS; k++) begin : g_stage
        loop_cnt_stage #(.WL(WL)) u_stage (
            .iCLK     (iCLK),
            .iRST     (iRST),
            .clear    (clearCnt),
            .advance  (advance),
            .carryIn  (carry[k]),
            .endCnt   (ecvReg[k]),
            .count    (oCNT[k*WL +: WL]),
            .carryOut (carry[k+1])
        );
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state   <= ST_IDLE;
            modeReg <= MODE_WRAP;
            oBUSY   <= 1'b0;
            oDONE   <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                ecvReg[k] <= WL'(ECV_DEF);
            end
        end else begin
            state   <= stateNext;
            modeReg <= modeNext;
            oBUSY   <= busyNext;
            oDONE   <= doneNext;
            if (loadEcv) begin
                for (int k = 0; k < NS; k++) begin
                    ecvReg[k] <= iECV[k*WL +: WL];
                end
            end
        end
    end

    // Clear outranks start/load, which outrank counting.
    always_comb begin
        stateNext = state;
        modeNext  = modeReg;
        doneNext  = 1'b0;
        loadEcv   = 1'b0;
        startRun  = 1'b0;
        if (iCLR) begin
            stateNext = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    loadEcv = iLOAD;
                    if (iSTART) begin
                        startRun  = 1'b1;
                        stateNext = ST_RUN;
                        modeNext  = iMODE;
                    end
                end
                ST_RUN: begin
                    if (iEN && carry[NS]) begin
                        doneNext = 1'b1;
                        if (modeReg == MODE_ONESHOT) begin
                            stateNext = ST_IDLE;
                        end
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
        busyNext = (stateNext == ST_RUN);
    end

endmodule

// File: tb/tb_loop_counter_nd.sv
// Scoreboard bench for loop_counter_nd: a behavioural model queues expected outputs per edge.
module tb_loop_counter_nd;

    localparam int unsigned NS = 3;
    localparam int unsigned WL = 8;

    logic             iCLK = 1'b0;
    logic             iRST, iCLR, iLOAD, iMODE, iSTART, iEN;
    logic [NS*WL-1:0] iECV;
    logic [NS*WL-1:0] oCNT;
    logic [NS-1:0]    oTC;
    logic             oBUSY, oDONE;

    typedef struct packed {
        logic [NS*WL-1:0] cnt;
        logic [NS-1:0]    tc;
        logic             busy;
        logic             done;
    } expT;

    expT  sb[$];
    int   nCmp = 0;
    int   nErr = 0;
    int   mCnt[NS];
    int   mEcv[NS];
    logic mRun, mMode;

    loop_counter_nd #(.NS(NS), .WL(WL), .ECV_DEF(13)) dut (
        .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR), .iLOAD(iLOAD), .iECV(iECV),
        .iMODE(iMODE), .iSTART(iSTART), .iEN(iEN),
        .oCNT(oCNT), .oTC(oTC), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    always #5 iCLK = ~iCLK;

    function automatic expT snap(input logic dn);
        expT e;
        logic allLow;
        e.busy = mRun;
        e.done = dn;
        allLow = 1'b1;
        for (int k = 0; k < NS; k++) begin
            e.cnt[k*WL +: WL] = WL'(mCnt[k]);
            allLow = allLow && (mCnt[k] == mEcv[k]);
            e.tc[k] = allLow;
        end
        return e;
    endfunction

    // Drive one edge's inputs, predict the outcome, queue it, then step past the edge.
    task automatic tick(input logic rst, input logic clr, input logic load,
                        input logic [NS*WL-1:0] ecv, input logic mode,
                        input logic start, input logic en);
        logic dn;
        logic allEnd;
        int   j;
        dn = 1'b0;
        iRST = rst; iCLR = clr; iLOAD = load; iECV = ecv;
        iMODE = mode; iSTART = start; iEN = en;
        if (!rst) begin
            for (int k = 0; k < NS; k++) begin mCnt[k] = 0; mEcv[k] = 13; end
            mRun = 1'b0; mMode = 1'b0;
        end else if (clr) begin
            for (int k = 0; k < NS; k++) mCnt[k] = 0;
            mRun = 1'b0;
        end else if (!mRun) begin
            if (load) for (int k = 0; k < NS; k++) mEcv[k] = int'(ecv[k*WL +: WL]);
            if (start) begin
                for (int k = 0; k < NS; k++) mCnt[k] = 0;
                mRun = 1'b1; mMode = mode;
            end
        end else if (en) begin
            allEnd = 1'b1;
            for (int k = 0; k < NS; k++) if (mCnt[k] != mEcv[k]) allEnd = 1'b0;
            if (allEnd) begin
                for (int k = 0; k < NS; k++) mCnt[k] = 0;
                dn = 1'b1;
                if (mMode) mRun = 1'b0;
            end else begin
                j = 0;
                while (mCnt[j] == mEcv[j]) begin mCnt[j] = 0; j++; end
                mCnt[j]++;
            end
        end
        sb.push_back(snap(dn));
        @(posedge iCLK);
        #1;
    endtask

    task automatic test_reset();
        expT e;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'($urandom), 1'($urandom), 24'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
            e = sb.pop_front();
            nCmp++;
            if ({oCNT, oTC, oBUSY, oDONE} !== e) begin
                nErr++;
                $display("FAIL reset[%0d] got cnt=%h tc=%b busy=%b done=%b exp %h",
                         i, oCNT, oTC, oBUSY, oDONE, e);
            end
        end
    endtask

    task automatic test_default_period();
        expT e;
        int  doneAt = 0, dones = 0;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i <= 2744; i++) begin
            if (i > 0) tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            nCmp++;
            if ({oCNT, oTC, oBUSY, oDONE} !== e) begin
                nErr++;
                $display("FAIL default_period en=%0d got cnt=%h tc=%b busy=%b done=%b exp %h",
                         i, oCNT, oTC, oBUSY, oDONE, e);
            end
            if (oDONE) begin doneAt = i; dones++; end
        end
        nCmp++;
        if (doneAt != 2744 || dones != 1 || oBUSY !== 1'b1) begin
            nErr++;
            $display("FAIL default_period_len got doneAt=%0d dones=%0d busy=%b exp 2744/1/1",
                     doneAt, dones, oBUSY);
        end
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
    endtask

    task automatic test_oneshot();
        expT e;
        int  doneAt = 0, dones = 0;
        tick(1'b1, 1'b0, 1'b1, 24'h020304, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i <= 62; i++) begin
            if (i > 0) tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            nCmp++;
            if ({oCNT, oTC, oBUSY, oDONE} !== e) begin
                nErr++;
                $display("FAIL oneshot en=%0d got cnt=%h tc=%b busy=%b done=%b exp %h",
                         i, oCNT, oTC, oBUSY, oDONE, e);
            end
            if (oDONE) begin doneAt = i; dones++; end
        end
        nCmp++;
        if (doneAt != 60 || dones != 1 || oBUSY !== 1'b0 || oCNT !== 24'h0) begin
            nErr++;
            $display("FAIL oneshot_end got doneAt=%0d dones=%0d busy=%b cnt=%h exp 60/1/0/0",
                     doneAt, dones, oBUSY, oCNT);
        end
    endtask

    task automatic test_wrap();
        expT e;
        int  dones = 0, firstAt = 0, lastAt = 0;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i <= 130; i++) begin
            if (i > 0) tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            nCmp++;
            if ({oCNT, oTC, oBUSY, oDONE} !== e) begin
                nErr++;
                $display("FAIL wrap en=%0d got cnt=%h tc=%b busy=%b done=%b exp %h",
                         i, oCNT, oTC, oBUSY, oDONE, e);
            end
            if (oDONE) begin
                dones++;
                if (dones == 1) firstAt = i;
                lastAt = i;
            end
        end
        nCmp++;
        if (dones != 2 || firstAt != 60 || lastAt != 120 || oBUSY !== 1'b1) begin
            nErr++;
            $display("FAIL wrap_dones got n=%0d at %0d,%0d busy=%b exp 2 at 60,120 busy=1",
                     dones, firstAt, lastAt, oBUSY);
        end
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        void'(sb.pop_front());
    endtask

    task automatic test_en_toggle();
        expT  e;
        int   nEn = 0, doneEn = 0;
        logic en;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 124; i++) begin
            en = (i % 2 == 0);
            tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, en);
            if (en) nEn++;
            e = sb.pop_front();
            nCmp++;
            if ({oCNT, oTC, oBUSY, oDONE} !== e) begin
                nErr++;
                $display("FAIL en_toggle cyc=%0d got cnt=%h tc=%b busy=%b done=%b exp %h",
                         i, oCNT, oTC, oBUSY, oDONE, e);
            end
            if (oDONE) doneEn = nEn;
        end
        nCmp++;
        if (doneEn != 60 || oBUSY !== 1'b0) begin
            nErr++;
            $display("FAIL en_toggle_done got doneEn=%0d busy=%b exp 60/0", doneEn, oBUSY);
        end
    endtask

    task automatic test_ignore_and_clear();
        expT e;
        int  doneAt = 0;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 33; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            void'(sb.pop_front());
        end
        tick(1'b1, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b1, 1'b0);
        e = sb.pop_front();
        nCmp++;
        if ({oCNT, oTC, oBUSY, oDONE} !== e || oCNT !== 24'h010203) begin
            nErr++;
            $display("FAIL ignore_start_load got cnt=%h busy=%b done=%b exp cnt=010203 (%h)",
                     oCNT, oBUSY, oDONE, e);
        end
        tick(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        nCmp++;
        if ({oCNT, oTC, oBUSY, oDONE} !== e || {oCNT, oBUSY, oDONE} !== 26'h0) begin
            nErr++;
            $display("FAIL clear_mid_run got cnt=%h busy=%b done=%b exp 0/0/0",
                     oCNT, oBUSY, oDONE);
        end
        // End-counts survive the clear: a fresh one-shot still takes 60 enables.
        tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 61; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            nCmp++;
            if ({oCNT, oTC, oBUSY, oDONE} !== e) begin
                nErr++;
                $display("FAIL after_clear en=%0d got cnt=%h tc=%b busy=%b done=%b exp %h",
                         i, oCNT, oTC, oBUSY, oDONE, e);
            end
            if (oDONE) doneAt = i;
        end
        nCmp++;
        if (doneAt != 60) begin
            nErr++;
            $display("FAIL ecv_kept got doneAt=%0d exp 60", doneAt);
        end
    endtask

    task automatic test_reset_mid_run();
        expT e;
        int  doneAt = 0;
        tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            void'(sb.pop_front());
        end
        tick(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        e = sb.pop_front();
        nCmp++;
        if ({oCNT, oTC, oBUSY, oDONE} !== e || {oCNT, oBUSY, oDONE} !== 26'h0) begin
            nErr++;
            $display("FAIL reset_mid_run got cnt=%h tc=%b busy=%b done=%b exp 0 (%h)",
                     oCNT, oTC, oBUSY, oDONE, e);
        end
        tick(1'b1, 1'b0, 1'b1, 24'h000005, 1'b1, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
            e = sb.pop_front();
            nCmp++;
            if ({oCNT, oTC, oBUSY, oDONE} !== e) begin
                nErr++;
                $display("FAIL zero_ecv en=%0d got cnt=%h tc=%b busy=%b done=%b exp %h",
                         i, oCNT, oTC, oBUSY, oDONE, e);
            end
            if (oDONE) doneAt = i;
        end
        nCmp++;
        if (doneAt != 6 || oBUSY !== 1'b0) begin
            nErr++;
            $display("FAIL zero_ecv_done got doneAt=%0d busy=%b exp 6/0", doneAt, oBUSY);
        end
    endtask

    initial begin
        iRST = 1'b0; iCLR = 1'b0; iLOAD = 1'b0; iECV = '0;
        iMODE = 1'b0; iSTART = 1'b0; iEN = 1'b0;
        for (int k = 0; k < NS; k++) begin mCnt[k] = 0; mEcv[k] = 13; end
        mRun = 1'b0; mMode = 1'b0;
        #1;
        test_reset();
        test_default_period();
        test_oneshot();
        test_wrap();
        test_en_toggle();
        test_ignore_and_clear();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
